// File: rtl/pipeline_signals.sv
// +------------------------------------------------------------------+
// | pipeline_signals: shared pipeline control/record types           |
// | Revision: 1.0 - MEM control, MEM/WB record, funct3 size codes    |
// +------------------------------------------------------------------+
`default_nettype none

package pipeline_signals;

  localparam logic [2:0] c_F3_B  = 3'b000;
  localparam logic [2:0] c_F3_H  = 3'b001;
  localparam logic [2:0] c_F3_W  = 3'b010;
  localparam logic [2:0] c_F3_BU = 3'b100;
  localparam logic [2:0] c_F3_HU = 3'b101;

  typedef struct packed {
    logic       MemRead;
    logic       MemWrite;
    logic [2:0] Funct3;
  } MEM_Control_t;

  typedef struct packed {
    logic        Valid;
    logic        RegWrite;
    logic [4:0]  rd;
    logic [31:0] Value;
    logic        LoadMisaligned;
    logic        StoreMisaligned;
    logic        AccessFault;
  } MEM_WB_t;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_BUS_WAIT = 1'b1
  } MEM_State_t;

  function automatic logic isLegalLoad(input logic [2:0] funct3);
    return (funct3 == c_F3_B) || (funct3 == c_F3_H) || (funct3 == c_F3_W) ||
           (funct3 == c_F3_BU) || (funct3 == c_F3_HU);
  endfunction

  function automatic logic isLegalStore(input logic [2:0] funct3);
    return (funct3 == c_F3_B) || (funct3 == c_F3_H) || (funct3 == c_F3_W);
  endfunction

  function automatic logic isAligned(input logic [2:0] funct3, input logic [1:0] lane);
    case (funct3)
      c_F3_H, c_F3_HU: return !lane[0];
      c_F3_W:          return (lane == 2'b00);
      default:         return 1'b1;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/stage_memory_access_lane_align.sv
// +------------------------------------------------------------------+
// | mem_lane_align: byte enables, store replication, load extension  |
// | Revision: 1.0 - initial                                          |
// +------------------------------------------------------------------+
`default_nettype none

module mem_lane_align
  import pipeline_signals::*;
(
  input  logic [2:0]  i_Funct3,
  input  logic [1:0]  i_Lane,
  input  logic [31:0] i_StoreData,
  input  logic [31:0] i_LoadData,
  output logic [3:0]  o_ByteEnable,
  output logic [31:0] o_WriteData,
  output logic [31:0] o_LoadValue
);

  logic [7:0]  w_Byte;
  logic [15:0] w_Half;

  always_comb begin
    o_ByteEnable = 4'b0000;
    o_WriteData  = i_StoreData;
    case (i_Funct3)
      c_F3_B, c_F3_BU: begin
        o_ByteEnable = 4'b0001 << i_Lane;
        o_WriteData  = {4{i_StoreData[7:0]}};
      end
      c_F3_H, c_F3_HU: begin
        o_ByteEnable = 4'b0011 << i_Lane;
        o_WriteData  = {2{i_StoreData[15:0]}};
      end
      c_F3_W: o_ByteEnable = 4'b1111;
      default: ;
    endcase
  end

  always_comb begin
    w_Byte = i_LoadData[7:0];
    case (i_Lane)
      2'd1:    w_Byte = i_LoadData[15:8];
      2'd2:    w_Byte = i_LoadData[23:16];
      2'd3:    w_Byte = i_LoadData[31:24];
      default: w_Byte = i_LoadData[7:0];
    endcase
    w_Half = i_Lane[1] ? i_LoadData[31:16] : i_LoadData[15:0];

    o_LoadValue = 32'h0;
    case (i_Funct3)
      c_F3_B:  o_LoadValue = {{24{w_Byte[7]}}, w_Byte};
      c_F3_BU: o_LoadValue = {24'h0, w_Byte};
      c_F3_H:  o_LoadValue = {{16{w_Half[15]}}, w_Half};
      c_F3_HU: o_LoadValue = {16'h0, w_Half};
      c_F3_W:  o_LoadValue = i_LoadData;
      default: o_LoadValue = 32'h0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/stage_memory_access.sv
// +------------------------------------------------------------------+
// | stage_memory_access: MEM pipeline stage with req/ack data bus    |
// | Revision: 1.0 - initial                                          |
// +------------------------------------------------------------------+
`default_nettype none

module stage_memory_access
  import pipeline_signals::*;
#(
  parameter int BUS_TIMEOUT_CYCLES = 16
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_Valid,
  input  logic        i_MemRead,
  input  logic        i_MemWrite,
  input  logic [2:0]  i_Funct3,
  input  logic [31:0] i_Address,
  input  logic [31:0] i_StoreData,
  input  logic        i_RegWrite,
  input  logic [4:0]  i_rd,
  output logic        o_Stall,
  output logic        o_BusReq,
  output logic        o_BusWrite,
  output logic [31:0] o_BusAddr,
  output logic [3:0]  o_BusByteEnable,
  output logic [31:0] o_BusWriteData,
  input  logic [31:0] i_BusReadData,
  input  logic        i_BusAck,
  output logic        o_WB_Valid,
  output logic        o_WB_RegWrite,
  output logic [4:0]  o_WB_rd,
  output logic [31:0] o_WB_Value,
  output logic        o_LoadMisaligned,
  output logic        o_StoreMisaligned,
  output logic        o_AccessFault
);

  MEM_State_t   r_State;
  MEM_WB_t      r_Wb;
  MEM_Control_t w_Ctl;
  logic [31:0]  r_TimeoutCnt;
  logic [2:0]   r_Funct3;
  logic [1:0]   r_Lane;
  logic [4:0]   r_Rd;
  logic         r_RegWrite;
  logic         r_IsStore;

  logic        w_IsMem, w_Legal, w_Aligned, w_Start, w_Timeout, w_Waiting;
  logic [2:0]  w_AlignFunct3;
  logic [1:0]  w_AlignLane;
  logic [3:0]  w_ByteEnable;
  logic [31:0] w_WriteData, w_LoadValue;

  assign w_Ctl     = '{MemRead: i_MemRead, MemWrite: i_MemWrite, Funct3: i_Funct3};
  assign w_Waiting = (r_State == ST_BUS_WAIT);
  assign w_IsMem   = w_Ctl.MemRead || w_Ctl.MemWrite;
  assign w_Legal   = w_Ctl.MemWrite ? isLegalStore(w_Ctl.Funct3) : isLegalLoad(w_Ctl.Funct3);
  assign w_Aligned = isAligned(w_Ctl.Funct3, i_Address[1:0]);
  assign w_Start   = !w_Waiting && i_Valid && w_IsMem && w_Legal && w_Aligned;
  assign w_Timeout = (BUS_TIMEOUT_CYCLES != 0) &&
                     (r_TimeoutCnt == 32'(BUS_TIMEOUT_CYCLES - 1));

  // Stall is combinational but must still read 0 while reset is held.
  assign o_Stall = i_Reset && (w_Waiting ? !i_BusAck : w_Start);

  // One aligner serves both the issuing instruction and the one on the bus.
  assign w_AlignFunct3 = w_Waiting ? r_Funct3 : i_Funct3;
  assign w_AlignLane   = w_Waiting ? r_Lane   : i_Address[1:0];

  mem_lane_align u_LaneAlign (
    .i_Funct3    (w_AlignFunct3),
    .i_Lane      (w_AlignLane),
    .i_StoreData (i_StoreData),
    .i_LoadData  (i_BusReadData),
    .o_ByteEnable(w_ByteEnable),
    .o_WriteData (w_WriteData),
    .o_LoadValue (w_LoadValue)
  );

  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      r_State         <= ST_IDLE;
      r_Wb            <= '0;
      r_TimeoutCnt    <= '0;
      r_Funct3        <= '0;
      r_Lane          <= '0;
      r_Rd            <= '0;
      r_RegWrite      <= 1'b0;
      r_IsStore       <= 1'b0;
      o_BusReq        <= 1'b0;
      o_BusWrite      <= 1'b0;
      o_BusAddr       <= '0;
      o_BusByteEnable <= '0;
      o_BusWriteData  <= '0;
    end else begin
      r_Wb.Valid           <= 1'b0;
      r_Wb.LoadMisaligned  <= 1'b0;
      r_Wb.StoreMisaligned <= 1'b0;
      r_Wb.AccessFault     <= 1'b0;
      case (r_State)
        ST_IDLE: begin
          if (i_Valid) begin
            if (!w_IsMem) begin
              r_Wb.Valid    <= 1'b1;
              r_Wb.Value    <= i_Address;
              r_Wb.rd       <= i_rd;
              r_Wb.RegWrite <= i_RegWrite && (i_rd != 5'd0);
            end else if (!w_Legal || !w_Aligned) begin
              r_Wb.Valid           <= 1'b1;
              r_Wb.Value           <= i_Address;
              r_Wb.rd              <= i_rd;
              r_Wb.RegWrite        <= 1'b0;
              r_Wb.AccessFault     <= !w_Legal;
              r_Wb.LoadMisaligned  <= w_Legal && !w_Ctl.MemWrite;
              r_Wb.StoreMisaligned <= w_Legal && w_Ctl.MemWrite;
            end else begin
              o_BusReq        <= 1'b1;
              o_BusWrite      <= w_Ctl.MemWrite;
              o_BusAddr       <= {i_Address[31:2], 2'b00};
              o_BusByteEnable <= w_ByteEnable;
              o_BusWriteData  <= w_WriteData;
              r_Funct3        <= i_Funct3;
              r_Lane          <= i_Address[1:0];
              r_Rd            <= i_rd;
              r_RegWrite      <= i_RegWrite;
              r_IsStore       <= w_Ctl.MemWrite;
              r_TimeoutCnt    <= '0;
              r_State         <= ST_BUS_WAIT;
            end
          end
        end
        ST_BUS_WAIT: begin
          if (i_BusAck) begin
            o_BusReq      <= 1'b0;
            r_Wb.Valid    <= 1'b1;
            r_Wb.Value    <= r_IsStore ? 32'h0 : w_LoadValue;
            r_Wb.rd       <= r_Rd;
            r_Wb.RegWrite <= !r_IsStore && r_RegWrite && (r_Rd != 5'd0);
            r_State       <= ST_IDLE;
          end else if (w_Timeout) begin
            o_BusReq         <= 1'b0;
            r_Wb.Valid       <= 1'b1;
            r_Wb.Value       <= o_BusAddr;
            r_Wb.rd          <= r_Rd;
            r_Wb.RegWrite    <= 1'b0;
            r_Wb.AccessFault <= 1'b1;
            r_State          <= ST_IDLE;
          end else begin
            r_TimeoutCnt <= r_TimeoutCnt + 32'd1;
          end
        end
        default: r_State <= ST_IDLE;
      endcase
    end
  end

  assign o_WB_Valid        = r_Wb.Valid;
  assign o_WB_RegWrite     = r_Wb.RegWrite;
  assign o_WB_rd           = r_Wb.rd;
  assign o_WB_Value        = r_Wb.Value;
  assign o_LoadMisaligned  = r_Wb.LoadMisaligned;
  assign o_StoreMisaligned = r_Wb.StoreMisaligned;
  assign o_AccessFault     = r_Wb.AccessFault;

endmodule

`default_nettype wire

// File: tb/tb_stage_memory_access.sv
// +------------------------------------------------------------------+
// | tb_stage_memory_access: directed vectors for the MEM stage       |
// | Revision: 1.0 - initial                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_stage_memory_access;

  logic        i_Clock = 1'b0;
  logic        i_Reset = 1'b0;
  logic        i_Valid = 1'b0, i_MemRead = 1'b0, i_MemWrite = 1'b0, i_RegWrite = 1'b0;
  logic [2:0]  i_Funct3 = '0;
  logic [31:0] i_Address = '0, i_StoreData = '0, i_BusReadData = '0;
  logic [4:0]  i_rd = '0;
  logic        i_BusAck = 1'b0;
  logic        o_Stall, o_BusReq, o_BusWrite, o_WB_Valid, o_WB_RegWrite;
  logic        o_LoadMisaligned, o_StoreMisaligned, o_AccessFault;
  logic [31:0] o_BusAddr, o_BusWriteData, o_WB_Value;
  logic [3:0]  o_BusByteEnable;
  logic [4:0]  o_WB_rd;

  int nTests = 0;
  int nFail  = 0;
  int gStall, gLat;
  logic gReq, gDone, gWrite;
  logic [31:0] gAddr, gWdata;
  logic [3:0]  gBe;

  stage_memory_access #(.BUS_TIMEOUT_CYCLES(4)) dut (
    .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Valid(i_Valid),
    .i_MemRead(i_MemRead), .i_MemWrite(i_MemWrite), .i_Funct3(i_Funct3),
    .i_Address(i_Address), .i_StoreData(i_StoreData), .i_RegWrite(i_RegWrite),
    .i_rd(i_rd), .o_Stall(o_Stall), .o_BusReq(o_BusReq), .o_BusWrite(o_BusWrite),
    .o_BusAddr(o_BusAddr), .o_BusByteEnable(o_BusByteEnable),
    .o_BusWriteData(o_BusWriteData), .i_BusReadData(i_BusReadData),
    .i_BusAck(i_BusAck), .o_WB_Valid(o_WB_Valid), .o_WB_RegWrite(o_WB_RegWrite),
    .o_WB_rd(o_WB_rd), .o_WB_Value(o_WB_Value), .o_LoadMisaligned(o_LoadMisaligned),
    .o_StoreMisaligned(o_StoreMisaligned), .o_AccessFault(o_AccessFault)
  );

  always #5 i_Clock = ~i_Clock;

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic present(input logic rd_, input logic wr_, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sd,
                         input logic [4:0] rd, input logic rw);
    i_Valid = 1'b1; i_MemRead = rd_; i_MemWrite = wr_; i_Funct3 = f3;
    i_Address = addr; i_StoreData = sd; i_rd = rd; i_RegWrite = rw;
  endtask

  // Cycle 0 is the issue cycle; ack is raised in wait cycle ackAt (0 = never).
  task automatic runBus(input int ackAt, input logic [31:0] rdata);
    gStall = 0; gLat = 0; gReq = 1'b0; gDone = 1'b0;
    gAddr = '0; gBe = '0; gWdata = '0; gWrite = 1'b0;
    for (int c = 0; c < 20 && !gDone; c++) begin
      i_BusAck = (ackAt > 0) && (c == ackAt);
      i_BusReadData = rdata;
      #1;
      if (o_Stall) gStall++;
      if (o_BusReq) gReq = 1'b1;
      if (c == 1) begin
        gAddr = o_BusAddr; gBe = o_BusByteEnable; gWdata = o_BusWriteData; gWrite = o_BusWrite;
      end
      @(posedge i_Clock); #1;
      i_BusAck = 1'b0;
      if (o_WB_Valid) begin
        gDone = 1'b1;
        gLat = c + 1;
      end
    end
    i_Valid = 1'b0;
    checkValue("retireWithinBound", 32'(gDone), 32'd1);
  endtask

  initial begin
    #12;
    checkValue("rstBusReq",  32'(o_BusReq), 0);
    checkValue("rstWbValid", 32'(o_WB_Valid), 0);
    checkValue("rstStall",   32'(o_Stall), 0);
    checkValue("rstBe",      32'(o_BusByteEnable), 0);
    checkValue("rstWbValue", o_WB_Value, 0);
    @(negedge i_Clock); i_Reset = 1'b1;
    @(posedge i_Clock); #1;

    // ADD pass-through
    present(0, 0, 3'b000, 32'h1234, 0, 5'd5, 1);
    runBus(0, 0);
    checkValue("addLat", gLat, 1);
    checkValue("addStall", gStall, 0);
    checkValue("addReq", 32'(gReq), 0);
    checkValue("addValue", o_WB_Value, 32'h1234);
    checkValue("addRd", 32'(o_WB_rd), 5);
    checkValue("addRegWrite", 32'(o_WB_RegWrite), 1);

    // LB 0x103, two wait cycles then ack
    present(1, 0, 3'b000, 32'h103, 0, 5'd7, 1);
    runBus(3, 32'h80FFFFFF);
    checkValue("lbAddr", gAddr, 32'h100);
    checkValue("lbBe", 32'(gBe), 32'b1000);
    checkValue("lbWrite", 32'(gWrite), 0);
    checkValue("lbStall", gStall, 3);
    checkValue("lbLat", gLat, 4);
    checkValue("lbValue", o_WB_Value, 32'hFFFFFF80);
    checkValue("lbRegWrite", 32'(o_WB_RegWrite), 1);
    checkValue("lbReqDrop", 32'(o_BusReq), 0);

    // SH 0x102
    present(0, 1, 3'b001, 32'h102, 32'h0000BEEF, 5'd9, 1);
    runBus(1, 0);
    checkValue("shBe", 32'(gBe), 32'b1100);
    checkValue("shWdata", gWdata, 32'hBEEFBEEF);
    checkValue("shWrite", 32'(gWrite), 1);
    checkValue("shLat", gLat, 2);
    checkValue("shRegWrite", 32'(o_WB_RegWrite), 0);

    // LW misaligned
    present(1, 0, 3'b010, 32'h102, 0, 5'd3, 1);
    runBus(0, 0);
    checkValue("lwMisReq", 32'(gReq), 0);
    checkValue("lwMisLat", gLat, 1);
    checkValue("lwMisFlag", 32'(o_LoadMisaligned), 1);
    checkValue("lwMisRegWrite", 32'(o_WB_RegWrite), 0);

    // SW misaligned, illegal load size
    present(0, 1, 3'b010, 32'h101, 0, 5'd3, 0);
    runBus(0, 0);
    checkValue("swMisFlag", 32'(o_StoreMisaligned), 1);
    checkValue("swMisLdFlag", 32'(o_LoadMisaligned), 0);
    present(1, 0, 3'b011, 32'h100, 0, 5'd3, 1);
    runBus(0, 0);
    checkValue("illegalFault", 32'(o_AccessFault), 1);
    checkValue("illegalReq", 32'(gReq), 0);

    // Extension variants
    present(1, 0, 3'b101, 32'h102, 0, 5'd4, 1);
    runBus(1, 32'h87654321);
    checkValue("lhuValue", o_WB_Value, 32'h00008765);
    present(1, 0, 3'b001, 32'h000, 0, 5'd4, 1);
    runBus(1, 32'h1234F00D);
    checkValue("lhValue", o_WB_Value, 32'hFFFFF00D);
    present(1, 0, 3'b100, 32'h101, 0, 5'd4, 1);
    runBus(2, 32'h0000AB00);
    checkValue("lbuValue", o_WB_Value, 32'h000000AB);
    checkValue("lbuBe", 32'(gBe), 32'b0010);
    present(1, 0, 3'b000, 32'h100, 0, 5'd0, 1);
    runBus(1, 32'h7F);
    checkValue("rd0RegWrite", 32'(o_WB_RegWrite), 0);

    // Timeout, then ack on the 4th wait cycle
    present(1, 0, 3'b010, 32'h200, 0, 5'd6, 1);
    runBus(0, 0);
    checkValue("toLat", gLat, 5);
    checkValue("toStall", gStall, 5);
    checkValue("toFault", 32'(o_AccessFault), 1);
    checkValue("toRegWrite", 32'(o_WB_RegWrite), 0);
    checkValue("toReqDrop", 32'(o_BusReq), 0);
    present(1, 0, 3'b010, 32'h200, 0, 5'd6, 1);
    runBus(4, 32'hDEADBEEF);
    checkValue("ackWinsFault", 32'(o_AccessFault), 0);
    checkValue("ackWinsValue", o_WB_Value, 32'hDEADBEEF);
    checkValue("ackWinsRegWrite", 32'(o_WB_RegWrite), 1);

    // Reset during BUS_WAIT
    present(1, 0, 3'b010, 32'h300, 0, 5'd8, 1);
    @(posedge i_Clock); #1;
    checkValue("preRstReq", 32'(o_BusReq), 1);
    #2 i_Reset = 1'b0;
    #1;
    checkValue("midRstReq", 32'(o_BusReq), 0);
    checkValue("midRstStall", 32'(o_Stall), 0);
    i_Valid = 1'b0;
    @(negedge i_Clock); i_Reset = 1'b1;
    @(posedge i_Clock); #1;
    present(0, 0, 3'b000, 32'hCAFE, 0, 5'd2, 1);
    runBus(0, 0);
    checkValue("postRstValue", o_WB_Value, 32'hCAFE);
    checkValue("postRstRd", 32'(o_WB_rd), 2);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

`default_nettype wire
